// File: rtl/decode_stage_pl.sv
// RV32I/RV32E decode stage: IF/ID register, register file, control decoder and immediate generator.
// Define WB_BYPASS_EN to forward the writeback port onto rd1_d/rd2_d in the same cycle.
module decode_stage_pl #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int          NUM_REGS      = 32,
  parameter logic [31:0] NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     reg_write_w,
  input  logic [4:0]               rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic [31:0]              instr_f,
  output logic                     valid_d,
  output logic                     illegal_d,
  output logic                     reg_write_d,
  output logic                     mem_write_d,
  output logic                     jump_d,
  output logic                     branch_d,
  output logic [1:0]               res_src_d,
  output logic [3:0]               alu_control_d,
  output logic [2:0]               funct3_d,
  output logic                     alu_src_a_d,
  output logic                     alu_src_b_d,
  output logic                     adder_src_d,
  output logic [DATA_WIDTH-1:0]    rd1_d,
  output logic [DATA_WIDTH-1:0]    rd2_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic [4:0]               rs1_d,
  output logic [4:0]               rs2_d,
  output logic [4:0]               rd_d,
  output logic [DATA_WIDTH-1:0]    imm_val_d
);

  localparam int       IdxW     = $clog2(NUM_REGS);
  localparam logic [5:0] NumRegsL = 6'(NUM_REGS);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT  = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  logic [31:0]              instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_q, pcPlus4_q;
  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    rf_q [NUM_REGS];

  // Flush shares the reset path: a bubble carries no PC and is never valid.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_d) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (!stall_d) begin
      instr_q   <= instr_f;
      pc_q      <= pc_f;
      pcPlus4_q <= pc_plus4_f;
      valid_q   <= 1'b1;
    end
  end

  logic wbEn;
  assign wbEn = reg_write_w && (rd_w != 5'd0) && ({1'b0, rd_w} < NumRegsL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wbEn) begin
      rf_q[rd_w[IdxW-1:0]] <= result_w;
    end
  end

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1Field, rs2Field, rdField;
  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign rs1Field = instr_q[19:15];
  assign rs2Field = instr_q[24:20];
  assign rdField  = instr_q[11:7];

  logic     legal, usesRs1, usesRs2, usesRd, isLui;
  logic     regWrite, memWrite, jump, branch, srcA, srcB, adderSrc;
  logic [1:0] resSrc;
  alu_op_e  aluOp;
  imm_sel_e immSel;

  always_comb begin
    legal    = 1'b0;
    usesRs1  = 1'b0;
    usesRs2  = 1'b0;
    usesRd   = 1'b0;
    isLui    = 1'b0;
    regWrite = 1'b0;
    memWrite = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    srcA     = 1'b0;
    srcB     = 1'b0;
    adderSrc = 1'b0;
    resSrc   = 2'b00;
    aluOp    = ALU_ADD;
    immSel   = IMM_NONE;
    case (opcode)
      7'b0110111: begin
        legal = 1'b1; regWrite = 1'b1; srcB = 1'b1; immSel = IMM_U; usesRd = 1'b1; isLui = 1'b1;
      end
      7'b0010111: begin
        legal = 1'b1; regWrite = 1'b1; srcA = 1'b1; srcB = 1'b1; immSel = IMM_U; usesRd = 1'b1;
      end
      7'b1101111: begin
        legal = 1'b1; regWrite = 1'b1; jump = 1'b1; resSrc = 2'b10; immSel = IMM_J; usesRd = 1'b1;
      end
      7'b1100111: begin
        legal = (funct3 == 3'b000); regWrite = 1'b1; jump = 1'b1; resSrc = 2'b10;
        adderSrc = 1'b1; srcB = 1'b1; immSel = IMM_I; usesRs1 = 1'b1; usesRd = 1'b1;
      end
      7'b1100011: begin
        legal = (funct3[2:1] != 2'b01); branch = 1'b1; aluOp = ALU_SUB; immSel = IMM_B;
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      7'b0000011: begin
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
        regWrite = 1'b1; resSrc = 2'b01; srcB = 1'b1; immSel = IMM_I; usesRs1 = 1'b1; usesRd = 1'b1;
      end
      7'b0100011: begin
        legal = !funct3[2] && (funct3[1:0] != 2'b11); memWrite = 1'b1; srcB = 1'b1;
        immSel = IMM_S; usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      7'b0010011: begin
        regWrite = 1'b1; srcB = 1'b1; immSel = IMM_I; usesRs1 = 1'b1; usesRd = 1'b1; legal = 1'b1;
        case (funct3)
          3'b000:  aluOp = ALU_ADD;
          3'b010:  aluOp = ALU_SLT;
          3'b011:  aluOp = ALU_SLTU;
          3'b100:  aluOp = ALU_XOR;
          3'b110:  aluOp = ALU_OR;
          3'b111:  aluOp = ALU_AND;
          3'b001: begin aluOp = ALU_SLL; legal = (funct7 == 7'b0000000); end
          default: begin
            aluOp = funct7[5] ? ALU_SRA : ALU_SRL;
            legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      7'b0110011: begin
        regWrite = 1'b1; usesRs1 = 1'b1; usesRs2 = 1'b1; usesRd = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  aluOp = ALU_ADD;
            3'b001:  aluOp = ALU_SLL;
            3'b010:  aluOp = ALU_SLT;
            3'b011:  aluOp = ALU_SLTU;
            3'b100:  aluOp = ALU_XOR;
            3'b101:  aluOp = ALU_SRL;
            3'b110:  aluOp = ALU_OR;
            default: aluOp = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          aluOp = (funct3 == 3'b101) ? ALU_SRA : ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  // RV32E: any register the instruction actually references must lie inside the file.
  logic badReg, live;
  assign badReg = (usesRs1 && ({1'b0, rs1Field} >= NumRegsL)) ||
                  (usesRs2 && ({1'b0, rs2Field} >= NumRegsL)) ||
                  (usesRd  && ({1'b0, rdField}  >= NumRegsL));
  assign illegal_d = valid_q && !(legal && !badReg);
  assign live      = valid_q && !illegal_d;

  assign valid_d       = valid_q;
  assign reg_write_d   = live && regWrite;
  assign mem_write_d   = live && memWrite;
  assign jump_d        = live && jump;
  assign branch_d      = live && branch;
  assign res_src_d     = resSrc;
  assign alu_control_d = aluOp;
  assign funct3_d      = funct3;
  assign alu_src_a_d   = srcA;
  assign alu_src_b_d   = srcB;
  assign adder_src_d   = adderSrc;
  assign pc_d          = pc_q;
  assign pc_plus4_d    = pcPlus4_q;
  assign rs1_d         = isLui ? 5'd0 : rs1Field;
  assign rs2_d         = usesRs2 ? rs2Field : 5'd0;
  assign rd_d          = rdField;

  logic [31:0] imm32;
  always_comb begin
    imm32 = 32'd0;
    case (immSel)
      IMM_I:   imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      IMM_S:   imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B:   imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      IMM_U:   imm32 = {instr_q[31:12], 12'd0};
      IMM_J:   imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end
  assign imm_val_d = {{(DATA_WIDTH - 31){imm32[31]}}, imm32[30:0]};

  logic rs1InRange, rs2InRange;
  assign rs1InRange = ({1'b0, rs1_d} < NumRegsL);
  assign rs2InRange = ({1'b0, rs2_d} < NumRegsL);

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1InRange && (rs1_d != 5'd0)) rd1_d = rf_q[rs1_d[IdxW-1:0]];
    if (rs2InRange && (rs2_d != 5'd0)) rd2_d = rf_q[rs2_d[IdxW-1:0]];
`ifdef WB_BYPASS_EN
    if (wbEn && (rd_w == rs1_d)) rd1_d = result_w;
    if (wbEn && (rd_w == rs2_d)) rd2_d = result_w;
`else
`endif
  end

endmodule

// File: tb/tb_decode_stage_pl.sv
// Directed bench for decode_stage_pl; a second instance is built as RV32E (NUM_REGS=16).
module tb_decode_stage_pl;

  logic        clk = 1'b0;
  logic        rst_n, stall_d, flush_d, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w, pc_f, pc_plus4_f, instr_f;

  logic        valid_d, illegal_d, reg_write_d, mem_write_d, jump_d, branch_d;
  logic [1:0]  res_src_d;
  logic [3:0]  alu_control_d;
  logic [2:0]  funct3_d;
  logic        alu_src_a_d, alu_src_b_d, adder_src_d;
  logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_val_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic        valid16, illegal16, regWrite16, memWrite16, jump16, branch16;
  logic [1:0]  resSrc16;
  logic [3:0]  aluCtl16;
  logic [2:0]  funct3_16;
  logic        srcA16, srcB16, adder16;
  logic [31:0] rd1_16, rd2_16, pc16, pcPlus4_16, imm16;
  logic [4:0]  rs1_16, rs2_16, rd16;

  always #5 clk = ~clk;

  decode_stage_pl dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .instr_f(instr_f),
    .valid_d(valid_d), .illegal_d(illegal_d), .reg_write_d(reg_write_d),
    .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d),
    .res_src_d(res_src_d), .alu_control_d(alu_control_d), .funct3_d(funct3_d),
    .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d), .adder_src_d(adder_src_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .imm_val_d(imm_val_d)
  );

  decode_stage_pl #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .instr_f(instr_f),
    .valid_d(valid16), .illegal_d(illegal16), .reg_write_d(regWrite16),
    .mem_write_d(memWrite16), .jump_d(jump16), .branch_d(branch16),
    .res_src_d(resSrc16), .alu_control_d(aluCtl16), .funct3_d(funct3_16),
    .alu_src_a_d(srcA16), .alu_src_b_d(srcB16), .adder_src_d(adder16),
    .rd1_d(rd1_16), .rd2_d(rd2_16), .pc_d(pc16), .pc_plus4_d(pcPlus4_16),
    .rs1_d(rs1_16), .rs2_d(rs2_16), .rd_d(rd16), .imm_val_d(imm16)
  );

  typedef struct {
    string       tag;
    logic        valid, illegal, rw, mw, jump, branch, srcA, srcB, adder;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    bit          chkImm, chkSrc, chkCtl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t base(input string tag, input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.valid = 1'b1; e.illegal = 1'b0; e.rw = 1'b0; e.mw = 1'b0;
    e.jump = 1'b0; e.branch = 1'b0; e.srcA = 1'b0; e.srcB = 1'b0; e.adder = 1'b0;
    e.res = 2'b00; e.alu = 4'd0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
    e.pc = pc; e.pc4 = pc + 32'd4; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.chkImm = 1'b1; e.chkSrc = 1'b1; e.chkCtl = 1'b1;
    return e;
  endfunction

  function automatic exp_t bubble(input string tag);
    exp_t e;
    e = base(tag, 32'd0);
    e.valid = 1'b0; e.pc4 = 32'd0; e.chkSrc = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic setWb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    reg_write_w = en; rd_w = rd; result_w = data;
  endtask

  task automatic applyStimulus(input exp_t e, input logic [31:0] instr, input logic [31:0] pc,
                               input logic stall, input logic flush);
    sb.push_back(e);
    instr_f = instr; pc_f = pc; pc_plus4_f = pc + 32'd4;
    stall_d = stall; flush_d = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".valid"},   32'(valid_d),     32'(e.valid));
    chk({e.tag, ".illegal"}, 32'(illegal_d),   32'(e.illegal));
    chk({e.tag, ".regw"},    32'(reg_write_d), 32'(e.rw));
    chk({e.tag, ".memw"},    32'(mem_write_d), 32'(e.mw));
    chk({e.tag, ".jump"},    32'(jump_d),      32'(e.jump));
    chk({e.tag, ".branch"},  32'(branch_d),    32'(e.branch));
    chk({e.tag, ".rd1"},     rd1_d,            e.rd1);
    chk({e.tag, ".rd2"},     rd2_d,            e.rd2);
    chk({e.tag, ".pc"},      pc_d,             e.pc);
    chk({e.tag, ".pc4"},     pc_plus4_d,       e.pc4);
    chk({e.tag, ".rs1"},     32'(rs1_d),       32'(e.rs1));
    chk({e.tag, ".rs2"},     32'(rs2_d),       32'(e.rs2));
    chk({e.tag, ".rd"},      32'(rd_d),        32'(e.rd));
    if (e.chkImm) chk({e.tag, ".imm"}, imm_val_d, e.imm);
    if (e.chkCtl) begin
      chk({e.tag, ".res"}, 32'(res_src_d),     32'(e.res));
      chk({e.tag, ".alu"}, 32'(alu_control_d), 32'(e.alu));
    end
    if (e.chkSrc) begin
      chk({e.tag, ".srcA"},  32'(alu_src_a_d), 32'(e.srcA));
      chk({e.tag, ".srcB"},  32'(alu_src_b_d), 32'(e.srcB));
      chk({e.tag, ".adder"}, 32'(adder_src_d), 32'(e.adder));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t e, beq;

    rst_n = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
    instr_f = 32'h00100093; pc_f = 32'h100; pc_plus4_f = 32'h104;
    sb.push_back(bubble("reset"));
    repeat (2) @(posedge clk);
    #1;
    checkOutput();

    // x2 is written on the same edge that loads addi x1,x0,1
    rst_n = 1'b1;
    setWb(1'b1, 5'd2, 32'h12345678);
    e = base("addi_x1", 32'h100); e.rw = 1; e.srcB = 1; e.imm = 32'd1; e.rd = 5'd1;
    applyStimulus(e, 32'h00100093, 32'h100, 1'b0, 1'b0);
    checkOutput();

    setWb(1'b1, 5'd5, 32'h55);
    e = base("add_x2", 32'h104); e.rw = 1; e.rd1 = 32'h12345678; e.rs1 = 5'd2; e.rd = 5'd2;
    e.chkImm = 1'b0;
    applyStimulus(e, 32'h00010133, 32'h104, 1'b0, 1'b0);
    checkOutput();

    // x3 write lands in the same cycle addi x4,x3,2 is being decoded
    setWb(1'b1, 5'd6, 32'h66);
    e = base("bypass", 32'h108); e.rw = 1; e.srcB = 1; e.imm = 32'd2; e.rs1 = 5'd3; e.rd = 5'd4;
`ifdef WB_BYPASS_EN
    e.rd1 = 32'hCAFEF00D;
`else
    e.rd1 = 32'd0;
`endif
    applyStimulus(e, 32'h00218213, 32'h108, 1'b0, 1'b0);
    setWb(1'b1, 5'd3, 32'hCAFEF00D);
    #1;
    checkOutput();

    beq = base("beq", 32'h10C); beq.branch = 1; beq.alu = 4'd1; beq.imm = 32'hFFFFFFFC;
    beq.rd1 = 32'h66; beq.rd2 = 32'h55; beq.rs1 = 5'd6; beq.rs2 = 5'd5; beq.rd = 5'd29;
    applyStimulus(beq, 32'hFE530EE3, 32'h10C, 1'b0, 1'b0);
    checkOutput();
    setWb(1'b0, 5'd0, 32'd0);

    for (int i = 0; i < 3; i++) begin
      beq.tag = $sformatf("stall%0d", i);
      applyStimulus(beq, 32'h0051A423, 32'h200, 1'b1, 1'b0);
      checkOutput();
    end

    e = base("sw", 32'h110); e.mw = 1; e.srcB = 1; e.imm = 32'd8; e.rd1 = 32'hCAFEF00D;
    e.rd2 = 32'h55; e.rs1 = 5'd3; e.rs2 = 5'd5; e.rd = 5'd8;
    applyStimulus(e, 32'h0051A423, 32'h110, 1'b0, 1'b0);
    checkOutput();

    applyStimulus(bubble("flush"), 32'h00A00093, 32'h114, 1'b1, 1'b1);
    checkOutput();

    e = base("jal", 32'h200); e.rw = 1; e.jump = 1; e.res = 2'b10; e.imm = 32'd8; e.rd = 5'd1;
    e.chkSrc = 1'b0;
    applyStimulus(e, 32'h008000EF, 32'h200, 1'b0, 1'b0);
    checkOutput();

    e = base("auipc", 32'h300); e.rw = 1; e.srcA = 1; e.srcB = 1; e.imm = 32'h1000; e.rd = 5'd8;
    applyStimulus(e, 32'h00001417, 32'h300, 1'b0, 1'b0);
    checkOutput();

    e = base("lui", 32'h304); e.rw = 1; e.srcB = 1; e.imm = 32'hABCDE000; e.rd = 5'd7;
    applyStimulus(e, 32'hABCDE3B7, 32'h304, 1'b0, 1'b0);
    checkOutput();

    e = base("illegal_op", 32'h308); e.illegal = 1; e.chkImm = 0; e.chkSrc = 0; e.chkCtl = 0;
    applyStimulus(e, 32'h0000007F, 32'h308, 1'b0, 1'b0);
    checkOutput();

    // x0 writes are held active across the next two decodes and must never appear
    setWb(1'b1, 5'd0, 32'hFFFFFFFF);
    e = base("add_x17", 32'h30C); e.rw = 1; e.rd2 = 32'h12345678; e.rs1 = 5'd1; e.rs2 = 5'd2;
    e.rd = 5'd17; e.chkImm = 1'b0;
    applyStimulus(e, 32'h002088B3, 32'h30C, 1'b0, 1'b0);
    checkOutput();
    chk("rv32e_x17.illegal", 32'(illegal16), 32'd1);
    chk("rv32e_x17.regw", 32'(regWrite16), 32'd0);

    e = base("add_x0", 32'h310); e.rw = 1; e.rd = 5'd1; e.chkImm = 1'b0;
    applyStimulus(e, 32'h000000B3, 32'h310, 1'b0, 1'b0);
    checkOutput();
    chk("rv32e_x0.rd1", rd1_16, 32'd0);
    chk("rv32e_x0.illegal", 32'(illegal16), 32'd0);
    setWb(1'b0, 5'd0, 32'd0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
